// File: rtl/pooling_layer_ctrl_if.sv
// Handshake and scan-index bundle between the pooling controller and its upstream/datapath.
// Ports: start, in_valid, in_ready, feature_idx/row/col, data_valid, win_last, busy, done, stall_cnt.
`timescale 1ns/1ps
interface pooling_layer_ctrl_if #(
  parameter int ROW_WIDTH     = 3,
  parameter int FEATURE_WIDTH = 2
);
  logic                     start;
  logic                     in_valid;
  logic                     in_ready;
  logic [FEATURE_WIDTH-1:0] feature_idx;
  logic [ROW_WIDTH-1:0]     feature_row;
  logic [ROW_WIDTH-1:0]     feature_col;
  logic                     data_valid;
  logic                     win_last;
  logic                     busy;
  logic                     done;
  logic [15:0]              stall_cnt;

  modport master (
    output start, in_valid,
    input  in_ready, feature_idx, feature_row, feature_col,
    input  data_valid, win_last, busy, done, stall_cnt
  );

  modport slave (
    input  start, in_valid,
    output in_ready, feature_idx, feature_row, feature_col,
    output data_valid, win_last, busy, done, stall_cnt
  );
endinterface

// File: rtl/pooling_layer_ctrl.sv
// Pooling-layer scan controller: walks feature/col/row over one map per start.
// Ports: clk, rst_n (async active-low), bus (slave modport); macro POOL_CTRL_STALL_CNT_EN adds stall counter.
`timescale 1ns/1ps
module pooling_layer_ctrl #(
  parameter int INPUT_SIZE    = 6,
  parameter int KERNEL_SIZE   = 2,
  parameter int TOTAL_FEATURE = 4
) (
  input logic                clk,
  input logic                rst_n,
  pooling_layer_ctrl_if.slave bus
);

  function automatic int logb2(input int value);
    int v;
    int n;
    v = value - 1;
    n = 0;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

  localparam int ROW_WIDTH     = logb2(INPUT_SIZE);
  localparam int FEATURE_WIDTH = logb2(TOTAL_FEATURE);

  localparam logic [ROW_WIDTH-1:0] RC_LAST =
    ROW_WIDTH'(INPUT_SIZE - 1);
  localparam logic [FEATURE_WIDTH-1:0] F_LAST =
    FEATURE_WIDTH'(TOTAL_FEATURE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [ROW_WIDTH-1:0]     r_row;
  logic [ROW_WIDTH-1:0]     r_col;
  logic [FEATURE_WIDTH-1:0] r_feat;
  logic                     r_in_ready;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_drain;

  logic w_fire;
  logic w_f_wrap;
  logic w_c_wrap;
  logic w_last;
  logic w_win_last;

  assign w_fire   = bus.in_valid & r_in_ready;
  assign w_f_wrap = (r_feat == F_LAST);
  assign w_c_wrap = (r_col == RC_LAST);
  assign w_last   = w_f_wrap & w_c_wrap & (r_row == RC_LAST);

  // Window closes on the bottom-right element of each KxK tile.
  assign w_win_last =
    ((int'(r_row) % KERNEL_SIZE) == KERNEL_SIZE - 1) &&
    ((int'(r_col) % KERNEL_SIZE) == KERNEL_SIZE - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_feat     <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drain    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_RUN;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_row      <= '0;
            r_col      <= '0;
            r_feat     <= '0;
          end
        end
        S_RUN: begin
          if (w_fire) begin
            if (w_last) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
              r_drain    <= 1'b0;
              r_row      <= '0;
              r_col      <= '0;
              r_feat     <= '0;
            end else if (w_f_wrap) begin
              r_feat <= '0;
              if (w_c_wrap) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end else begin
              r_feat <= r_feat + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Two-cycle drain: r_drain marks the second cycle.
          if (r_drain) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef POOL_CTRL_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_stall <= '0;
    end else if (r_state == S_RUN && !bus.in_valid &&
                 r_stall != 16'hFFFF) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign bus.stall_cnt = r_stall;
`else
  assign bus.stall_cnt = '0;
`endif

  assign bus.in_ready    = r_in_ready;
  assign bus.feature_idx = r_feat;
  assign bus.feature_row = r_row;
  assign bus.feature_col = r_col;
  assign bus.data_valid  = w_fire;
  assign bus.win_last    = w_win_last;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_pooling_layer_ctrl.sv
// Directed bench for pooling_layer_ctrl with default parameters.
// Drives start/in_valid via the interface; checks with immediate assertions.
`timescale 1ns/1ps
module tb_pooling_layer_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pooling_layer_ctrl_if #(
    .ROW_WIDTH    (3),
    .FEATURE_WIDTH(2)
  ) bus ();

  pooling_layer_ctrl #(
    .INPUT_SIZE   (6),
    .KERNEL_SIZE  (2),
    .TOTAL_FEATURE(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef POOL_CTRL_STALL_CNT_EN
  localparam int STALL_EXP = 5;
`else
  localparam int STALL_EXP = 0;
`endif

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_rdy"}, int'(bus.in_ready), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_dv"}, int'(bus.data_valid), 0);
    chk({tag, "_row"}, int'(bus.feature_row), 0);
    chk({tag, "_col"}, int'(bus.feature_col), 0);
    chk({tag, "_feat"}, int'(bus.feature_idx), 0);
  endtask

  // Caller sits at posedge+1 of an IDLE cycle (cycle 0).
  task automatic run_pass(input string tag);
    int beats, busyc, donec, ndone, oerr, wl, wlerr;
    int er, ec, ef;
    bit exp_wl;
    beats = 0; busyc = 0; donec = -1; ndone = 0;
    oerr = 0; wl = 0; wlerr = 0;
    er = 0; ec = 0; ef = 0;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    nxt();
    bus.start = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (bus.busy) busyc++;
      if (bus.done) begin
        ndone++;
        donec = c;
      end
      if (bus.data_valid) begin
        if (int'(bus.feature_row) != er ||
            int'(bus.feature_col) != ec ||
            int'(bus.feature_idx) != ef) oerr++;
        exp_wl = ((er % 2) == 1) && ((ec % 2) == 1);
        if (bus.win_last != exp_wl) wlerr++;
        if (bus.win_last) wl++;
        beats++;
        ef++;
        if (ef == 4) begin
          ef = 0;
          ec++;
          if (ec == 6) begin
            ec = 0;
            er++;
          end
        end
      end
      nxt();
    end
    chk({tag, "_beats"}, beats, 144);
    chk({tag, "_busy_cycles"}, busyc, 147);
    chk({tag, "_done_cycle"}, donec, 147);
    chk({tag, "_done_count"}, ndone, 1);
    chk({tag, "_order_err"}, oerr, 0);
    chk({tag, "_winlast_err"}, wlerr, 0);
    chk({tag, "_winlast_cnt"}, wl, 36);
    chk_idle({tag, "_end"});
  endtask

  initial begin
    int ndone;
    int bound;
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    #2;
    chk_idle("reset");
    chk("reset_stall", int'(bus.stall_cnt), 0);
    nxt();
    nxt();
    rst_n = 1'b1;
    nxt();

    run_pass("pass1");

    // Stall at element (2,3,1) = index 61.
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    nxt();
    bus.start = 1'b0;
    repeat (61) nxt();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_dv", int'(bus.data_valid), 0);
      chk("stall_row", int'(bus.feature_row), 2);
      chk("stall_col", int'(bus.feature_col), 3);
      chk("stall_feat", int'(bus.feature_idx), 1);
      chk("stall_rdy", int'(bus.in_ready), 1);
      nxt();
    end
    @(negedge clk);
    chk("stall_cnt", int'(bus.stall_cnt), STALL_EXP);
    chk("stall_resume_dv", 1, 1 & int'(!bus.data_valid));
    bus.in_valid = 1'b1;
    nxt();
    ndone = 0;
    bound = 0;
    while (bus.busy && bound < 200) begin
      @(negedge clk);
      if (bus.done) ndone++;
      nxt();
      bound++;
    end
    chk("stall_pass_bound", int'(bound < 200), 1);
    chk("stall_pass_done", ndone, 1);
    chk("stall_cnt_hold", int'(bus.stall_cnt), STALL_EXP);

    // start in RUN and in DONE is ignored.
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    nxt();
    bus.start = 1'b0;
    repeat (9) nxt();
    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    ndone = 0;
    bound = 0;
    @(negedge clk);
    while (!bus.done && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    chk("restart_bound", int'(bound < 200), 1);
    ndone = int'(bus.done);
    bus.start = 1'b1;
    nxt();
    chk("done_start_busy", int'(bus.busy), 0);
    chk("done_start_done", int'(bus.done), 0);
    chk("single_done", ndone, 1);
    nxt();
    bus.start = 1'b0;
    chk("restart_busy", int'(bus.busy), 1);
    chk("restart_dv", int'(bus.data_valid), 1);
    chk("restart_row", int'(bus.feature_row), 0);
    chk("restart_col", int'(bus.feature_col), 0);
    chk("restart_feat", int'(bus.feature_idx), 0);

    // Advance to element 70 = (2,5,2), then reset mid-pass.
    repeat (70) nxt();
    chk("e70_row", int'(bus.feature_row), 2);
    chk("e70_col", int'(bus.feature_col), 5);
    chk("e70_feat", int'(bus.feature_idx), 2);
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    chk("midrst_stall", int'(bus.stall_cnt), 0);
    bus.in_valid = 1'b0;
    nxt();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
      nxt();
    end
    chk("midrst_no_done", ndone, 0);

    run_pass("pass2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pooling_layer_ctrl.md
POOLING_LAYER_CTRL -- requirements
Module: pooling_layer_ctrl

Interface
REQ-001 The block SHALL take parameter INPUT_SIZE, default 6: feature-map width and height in elements.
REQ-002 The block SHALL take parameter KERNEL_SIZE, default 2: pooling window edge and stride.
REQ-003 The block SHALL take parameter TOTAL_FEATURE, default 4: number of feature maps interleaved per pixel.
REQ-004 The block SHALL define localparams ROW_WIDTH = logb2(INPUT_SIZE) and FEATURE_WIDTH = logb2(TOTAL_FEATURE), using the pooling-layer logb2 function.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: request one full-map pass; sampled in IDLE only.
REQ-008 The block SHALL have port in_valid, input, 1 bit: an upstream element is present this cycle.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the element is consumed when in_valid and in_ready are both high; in_ready is high in RUN only.
REQ-010 The block SHALL have port feature_idx, output, FEATURE_WIDTH bits: the feature of the current element.
REQ-011 The block SHALL have port feature_row, output, ROW_WIDTH bits: the row of the current element.
REQ-012 The block SHALL have port feature_col, output, ROW_WIDTH bits: the column of the current element.
REQ-013 The block SHALL have port data_valid, output, 1 bit: in_valid AND in_ready (combinational), driving datapath input_valid.
REQ-014 The block SHALL have port win_last, output, 1 bit: the current element closes a pooling window (row mod KERNEL_SIZE = KERNEL_SIZE-1 and col mod KERNEL_SIZE = KERNEL_SIZE-1).
REQ-015 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes.
REQ-017 The block SHALL have port stall_cnt, output, 16 bits: the stall counter (see Configuration).

Function
REQ-018 The block SHALL be a four-state machine: IDLE -> RUN on start; RUN -> DRAIN on the handshake of the final element; DRAIN -> DONE after exactly 2 cycles; DONE -> IDLE after 1 cycle.
REQ-019 Scan order SHALL be feature innermost, then column, then row, each counting from 0 upward; each counter advances only on a handshake.
REQ-020 feature_idx SHALL wrap from TOTAL_FEATURE-1 to 0 and carry into feature_col; feature_col SHALL wrap from INPUT_SIZE-1 to 0 and carry into feature_row.
REQ-021 The final element SHALL be row = col = INPUT_SIZE-1 and feature = TOTAL_FEATURE-1; its handshake SHALL clear all counters to 0 and enter DRAIN.
REQ-022 A pass SHALL consume exactly INPUT_SIZE*INPUT_SIZE*TOTAL_FEATURE handshakes, which is 144 with the defaults.
REQ-023 With in_valid held high, the timing SHALL be: start in cycle 0, RUN in cycles 1-144, DRAIN in cycles 145-146, done high in cycle 147, IDLE in cycle 148.
REQ-024 When in_valid is low in RUN, all counters SHALL hold and data_valid SHALL be 0.
REQ-025 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-026 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-027 win_last SHALL be qualified by the counter values only; the consumer gates it with data_valid.
REQ-028 Outputs other than data_valid and win_last SHALL be registered.

Reset
REQ-029 rst_n low SHALL force IDLE asynchronously, including mid-pass, and abandon the pass without a done pulse.
REQ-030 The reset values SHALL be: feature_idx, feature_row and feature_col 0; in_ready, busy and done 0; stall_cnt 0.
REQ-031 The first start after rst_n deasserts SHALL begin a fresh pass from element (0,0,0).

Configuration
REQ-032 When macro POOL_CTRL_STALL_CNT_EN is defined, stall_cnt SHALL clear on entry to RUN, increment for each RUN cycle with in_valid low, saturate at 16'hFFFF, and hold its value outside RUN.
REQ-033 When POOL_CTRL_STALL_CNT_EN is undefined, stall_cnt SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-034 Reset, then a 1-cycle start with in_valid held high -> 144 data_valid beats, busy high cycles 1-147, done exactly at cycle 147.
REQ-035 Start, then hold in_valid low for 5 cycles at element (row 2, col 3, feature 1) -> counters hold, data_valid 0; stall_cnt = 5 with the macro defined, 0 without it.
REQ-036 A full pass -> win_last high at (1,1,f), (1,3,f), (5,5,f) for every f, and low at (0,1,f) and (1,0,f).
REQ-037 start pulsed during RUN and in the DONE cycle -> no restart and a single done pulse; start one cycle later -> a new pass from (0,0,0).
REQ-038 rst_n pulsed low at element 70 -> immediate IDLE, all outputs 0, no done; a subsequent start completes a full 144-beat pass.
